last_set_scheduler: RTL

- Round-robin scheduler that shares one `last_set` highest-set-bit unit among `N_REQ` fixed-point requesters.
- Takes one request at a time and drives the unit's `start`/`location_valid` handshake.
- Bypasses the unit when the integer part of the vector is zero, since the unit never completes on that input.
- Guards each job with a timeout, then returns the location to the owning requester.

---
 rtl/last_set_scheduler_if.sv | 27 ++
 rtl/last_set_scheduler.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/last_set_scheduler_if.sv
// Bundle between the requesters / shared last_set unit and the scheduler.
// Master is the environment (requesters plus the unit); slave is the scheduler.
interface last_set_scheduler_if #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 16
);
    logic [N_REQ-1:0]       req_valid;
    logic [N_REQ*WIDTH-1:0] req_vector;
    logic [N_REQ-1:0]       req_ready;
    logic [N_REQ-1:0]       resp_valid;
    logic [5:0]             resp_location;
    logic                   resp_err;
    logic                   lz_start;
    logic [WIDTH-1:0]       lz_vector;
    logic [5:0]             lz_location;
    logic                   lz_valid;

    modport master (
        output req_valid, req_vector, lz_location, lz_valid,
        input  req_ready, resp_valid, resp_location, resp_err, lz_start, lz_vector
    );

    modport slave (
        input  req_valid, req_vector, lz_location, lz_valid,
        output req_ready, resp_valid, resp_location, resp_err, lz_start, lz_vector
    );
endinterface

// File: rtl/last_set_scheduler.sv
// Round-robin scheduler sharing one last_set highest-set-bit unit among N_REQ requesters,
// with a zero-integer-part bypass and a per-job timeout.
module last_set_scheduler #(
    parameter int N_REQ    = 4,
    parameter int WIDTH    = 16,
    parameter int FP_B     = 4,
    parameter int MAX_WAIT = 16
) (
    input  logic                clk,
    input  logic                rst_,
    last_set_scheduler_if.slave bus
);
    localparam int OW = $clog2(N_REQ);
    localparam int CW = $clog2(MAX_WAIT + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_r;
    state_t           state_s;
    logic [OW-1:0]    ptr_r;
    logic [OW-1:0]    owner_r;
    logic [OW-1:0]    win_s;
    logic [OW:0]      scan_raw_s;
    logic [OW:0]      scan_s;
    logic             found_s;
    logic [WIDTH-1:0] vec_r;
    logic [WIDTH-1:0] sel_vec_s;
    logic             int_zero_s;
    logic [CW-1:0]    cnt_r;
    logic             timeout_s;
    logic [5:0]       loc_r;
    logic             err_r;
    logic             lz_start_r;
    logic [N_REQ-1:0] resp_valid_r;
    logic [N_REQ-1:0] ready_s;

    function automatic logic [N_REQ-1:0] onehot(input logic [OW-1:0] idx);
        onehot = N_REQ'(1'b1) << idx;
    endfunction

    assign sel_vec_s  = bus.req_vector[int'(win_s) * WIDTH +: WIDTH];
    // The unit never completes on a vector with an all-zero integer part.
    assign int_zero_s = (sel_vec_s[WIDTH-1:FP_B] == '0);
    assign timeout_s  = (cnt_r == CW'(MAX_WAIT - 1));

    // Round-robin winner search; scanning backwards lets the slot at ptr override the rest.
    always_comb begin
        found_s    = 1'b0;
        win_s      = '0;
        scan_raw_s = '0;
        scan_s     = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            scan_raw_s = {1'b0, ptr_r} + (OW+1)'(k);
            scan_s     = (scan_raw_s >= (OW+1)'(N_REQ)) ? scan_raw_s - (OW+1)'(N_REQ) : scan_raw_s;
            found_s    = found_s | bus.req_valid[scan_s[OW-1:0]];
            win_s      = bus.req_valid[scan_s[OW-1:0]] ? scan_s[OW-1:0] : win_s;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst_) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic; a valid from the unit wins over a coincident timeout.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (found_s) state_s = int_zero_s ? DONE : BUSY;
                else         state_s = IDLE;
            end
            BUSY: begin
                if (bus.lz_valid || timeout_s) state_s = DONE;
                else                           state_s = BUSY;
            end
            DONE:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // Grant output: combinational one-hot, only in IDLE and never while reset is asserted.
    always_comb begin
        ready_s = '0;
        if ((state_r == IDLE) && !rst_ && found_s) ready_s = onehot(win_s);
        else                                       ready_s = '0;
    end

    // Job datapath: capture, wait counting, result latch and completion pulse.
    always_ff @(posedge clk) begin
        if (rst_) begin
            ptr_r        <= '0;
            owner_r      <= '0;
            vec_r        <= '0;
            cnt_r        <= '0;
            loc_r        <= 6'd0;
            err_r        <= 1'b0;
            lz_start_r   <= 1'b0;
            resp_valid_r <= '0;
        end else begin
            resp_valid_r <= '0;
            case (state_r)
                IDLE: begin
                    if (found_s) begin
                        vec_r      <= sel_vec_s;
                        owner_r    <= win_s;
                        cnt_r      <= '0;
                        lz_start_r <= !int_zero_s;
                        if (int_zero_s) begin
                            loc_r        <= 6'd0;
                            err_r        <= 1'b0;
                            resp_valid_r <= onehot(win_s);
                        end
                    end
                end
                BUSY: begin
                    cnt_r <= cnt_r + CW'(1);
                    if (bus.lz_valid) begin
                        loc_r        <= bus.lz_location;
                        err_r        <= 1'b0;
                        lz_start_r   <= 1'b0;
                        resp_valid_r <= onehot(owner_r);
                    end else if (timeout_s) begin
                        loc_r        <= 6'd0;
                        err_r        <= 1'b1;
                        lz_start_r   <= 1'b0;
                        resp_valid_r <= onehot(owner_r);
                    end
                end
                DONE: begin
                    ptr_r <= (owner_r == OW'(N_REQ - 1)) ? '0 : owner_r + OW'(1);
                end
                default: begin
                    lz_start_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.req_ready     = ready_s;
    assign bus.resp_valid    = resp_valid_r;
    assign bus.resp_location = loc_r;
    assign bus.resp_err      = err_r;
    assign bus.lz_start      = lz_start_r;
    assign bus.lz_vector     = vec_r;
endmodule
